adaptive_filter_mode_ctrl: RTL and testbench

- Sequencer in front of adaptive_filter that owns the filter's ctrl (mode) and srst inputs.
- Accepts mode-change requests and safely switches between differentiator (0) and integrator (1) with drain → reset → settle sequencing.
- Gates the sample stream with a valid/ready handshake and blanks outputs while the filter history is invalid.
- The filter itself is free-running: one sample per clk, combinational output.

---
 rtl/adaptive_filter_mode_ctrl_if.sv | 41 ++++
 rtl/adaptive_filter_mode_ctrl.sv | 141 ++++++++++++++
 tb/tb_adaptive_filter_mode_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adaptive_filter_mode_ctrl_if.sv
// -----------------------------------------------------------------------------
// adaptive_filter_mode_ctrl_if
// Bundle of every non-clock/reset signal of the mode sequencer.
//   mode request : mode_req_valid, mode_req, mode_req_ready
//   sample in    : s_tvalid, s_tready, s_tdata
//   filter side  : filt_s_tdata, filt_ctrl, filt_srst, filt_m_tdata
//   sample out   : m_tvalid, m_tdata
//   status       : mode, busy, switch_done
// Modport slave is the controller; modport master is whoever drives it.
// -----------------------------------------------------------------------------
interface adaptive_filter_mode_ctrl_if #(
    parameter int DATA_WIDTH = 14
);
    logic                  mode_req_valid;
    logic                  mode_req;
    logic                  mode_req_ready;
    logic                  s_tvalid;
    logic                  s_tready;
    logic [DATA_WIDTH-1:0] s_tdata;
    logic [DATA_WIDTH-1:0] filt_s_tdata;
    logic                  filt_ctrl;
    logic                  filt_srst;
    logic [DATA_WIDTH-1:0] filt_m_tdata;
    logic                  m_tvalid;
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  mode;
    logic                  busy;
    logic                  switch_done;

    modport slave (
        input  mode_req_valid, mode_req, s_tvalid, s_tdata, filt_m_tdata,
        output mode_req_ready, s_tready, filt_s_tdata, filt_ctrl, filt_srst,
               m_tvalid, m_tdata, mode, busy, switch_done
    );

    modport master (
        output mode_req_valid, mode_req, s_tvalid, s_tdata, filt_m_tdata,
        input  mode_req_ready, s_tready, filt_s_tdata, filt_ctrl, filt_srst,
               m_tvalid, m_tdata, mode, busy, switch_done
    );
endinterface

// File: rtl/adaptive_filter_mode_ctrl.sv
// -----------------------------------------------------------------------------
// adaptive_filter_mode_ctrl
// Sequencer owning the mode (ctrl) and sync reset of a free-running
// differentiator/integrator filter. A mode change drains the old-mode tail
// with zero samples, resets the filter, then blanks the output while the new
// history fills.
//   clk    : system clock
//   arst_n : asynchronous active-low reset
//   bus    : adaptive_filter_mode_ctrl_if.slave (request, streams, filter, status)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_INIT   | one cycle after reset, filter held in srst
// ST_RUN    | normal streaming, mode requests accepted
// ST_DRAIN  | zero samples fed, old-mode tail still emitted
// ST_SWITCH | filter srst pulse, new mode committed at cycle end
// ST_SETTLE | samples enter under new mode, output blanked
// -----------------------------------------------------------------------------
module adaptive_filter_mode_ctrl #(
    parameter int DATA_WIDTH    = 14,
    parameter int DRAIN_CYCLES  = 5,
    parameter int SETTLE_CYCLES = 8,
    parameter bit INIT_MODE     = 1'b0
) (
    input  logic                       clk,
    input  logic                       arst_n,
    adaptive_filter_mode_ctrl_if.slave bus
);

    localparam int MAX_CYC = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_RUN,
        ST_DRAIN,
        ST_SWITCH,
        ST_SETTLE
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_pend;
    logic                  r_mode;
    logic                  r_srst;
    logic                  r_busy;
    logic                  r_m_tvalid;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic                  r_switch_done;

    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_pend_nxt;
    logic                  w_mode_nxt;
    logic                  w_m_tvalid_nxt;
    logic                  w_run;
    logic                  w_settle;
    logic                  w_take;
    logic                  w_req_switch;

    assign w_run        = (r_state == ST_RUN);
    assign w_settle     = (r_state == ST_SETTLE);
    assign w_take       = (w_run || w_settle) && bus.s_tvalid;
    assign w_req_switch = w_run && bus.mode_req_valid && (bus.mode_req != r_mode);

    assign bus.s_tready       = w_run || w_settle;
    assign bus.mode_req_ready = w_run;
    // Bubbles and non-streaming states feed zeros: the filter advances every clk.
    assign bus.filt_s_tdata   = w_take ? bus.s_tdata : '0;
    assign bus.filt_ctrl      = r_mode;
    assign bus.mode           = r_mode;
    assign bus.filt_srst      = r_srst;
    assign bus.busy           = r_busy;
    assign bus.m_tvalid       = r_m_tvalid;
    assign bus.m_tdata        = r_m_tdata;
    assign bus.switch_done    = r_switch_done;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_mode_nxt  = r_mode;
        case (r_state)
            ST_INIT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_req_switch) begin
                    w_pend_nxt = bus.mode_req;
                    w_cnt_nxt  = '0;
                    if (DRAIN_CYCLES == 0) w_state_nxt = ST_SWITCH;
                    else                   w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == DRAIN_LAST) w_state_nxt = ST_SWITCH;
                else                     w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            ST_SWITCH: begin
                w_mode_nxt = r_pend;
                w_cnt_nxt  = '0;
                if (SETTLE_CYCLES == 0) w_state_nxt = ST_RUN;
                else                    w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_cnt == SETTLE_LAST) w_state_nxt = ST_RUN;
                else                      w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Drain keeps the output valid so the old-mode tail reaches the consumer.
    assign w_m_tvalid_nxt = (w_run && bus.s_tvalid) || (r_state == ST_DRAIN);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state       <= ST_INIT;
            r_cnt         <= '0;
            r_pend        <= INIT_MODE;
            r_mode        <= INIT_MODE;
            r_srst        <= 1'b1;
            r_busy        <= 1'b1;
            r_m_tvalid    <= 1'b0;
            r_m_tdata     <= '0;
            r_switch_done <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pend        <= w_pend_nxt;
            r_mode        <= w_mode_nxt;
            r_srst        <= (w_state_nxt == ST_SWITCH);
            r_busy        <= (w_state_nxt != ST_RUN);
            r_m_tvalid    <= w_m_tvalid_nxt;
            r_m_tdata     <= w_m_tvalid_nxt ? bus.filt_m_tdata : '0;
            r_switch_done <= (w_state_nxt == ST_RUN) &&
                             ((r_state == ST_SWITCH) || (r_state == ST_SETTLE));
        end
    end

endmodule

// File: tb/tb_adaptive_filter_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adaptive_filter_mode_ctrl
// Drives the sequencer with random samples and random filter responses and
// compares every output against a timeline model: each mode change is a fixed
// schedule of drain, switch and settle cycles counted from the cycle the
// request was accepted.
// -----------------------------------------------------------------------------
module tb_adaptive_filter_mode_ctrl;

    localparam int DW = 14;
    localparam int D  = 5;
    localparam int S  = 8;
    localparam bit IM = 1'b0;

    logic clk    = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    adaptive_filter_mode_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    adaptive_filter_mode_ctrl #(
        .DATA_WIDTH   (DW),
        .DRAIN_CYCLES (D),
        .SETTLE_CYCLES(S),
        .INIT_MODE    (IM)
    ) dut (
        .clk   (clk),
        .arst_n(arst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // timeline model
    int          cyc;
    bit          sw_active;
    int          sw_t;
    bit          cur_mode;
    bit          pend_mode;
    bit          nxt_v;
    logic [DW-1:0] nxt_d;

    // expected values for the current cycle
    bit          e_busy, e_srst, e_tready, e_rready, e_mode, e_done, e_mv;
    logic [DW-1:0] e_md, e_fs;

    // observed values
    logic        o_busy, o_srst, o_tready, o_rready, o_mode, o_ctrl, o_done, o_mv;
    logic [DW-1:0] o_md, o_fs;
    int          o_cyc;

    task automatic capture();
        o_busy   = bus.busy;
        o_srst   = bus.filt_srst;
        o_tready = bus.s_tready;
        o_rready = bus.mode_req_ready;
        o_mode   = bus.mode;
        o_ctrl   = bus.filt_ctrl;
        o_done   = bus.switch_done;
        o_mv     = bus.m_tvalid;
        o_md     = bus.m_tdata;
        o_fs     = bus.filt_s_tdata;
        o_cyc    = cyc;
    endtask

    task automatic model_reset();
        cyc       = 0;
        sw_active = 1'b0;
        sw_t      = 0;
        cur_mode  = IM;
        pend_mode = IM;
        nxt_v     = 1'b0;
        nxt_d     = '0;
    endtask

    // Assert reset mid-cycle, sample outputs while it is low, release one
    // cycle later just after the edge: that cycle is model cycle 0 (INIT).
    task automatic pulse_reset();
        #2 arst_n = 1'b0;
        #1 capture();
        @(posedge clk);
        #1 arst_n = 1'b1;
        model_reset();
    endtask

    // One clock cycle: apply inputs, predict, sample at negedge, advance.
    task automatic tick(input bit v, input logic [DW-1:0] d, input bit rv, input bit rm);
        bit run;
        bit drain;
        int k;
        run   = 1'b0;
        drain = 1'b0;
        k     = 0;
        bus.s_tvalid       = v;
        bus.s_tdata        = d;
        bus.mode_req_valid = rv;
        bus.mode_req       = rm;
        bus.filt_m_tdata   = DW'($urandom);

        e_mv   = nxt_v;
        e_md   = nxt_d;
        e_done = 1'b0;
        if (cyc == 0) begin
            e_busy = 1'b1; e_srst = 1'b1; e_tready = 1'b0; e_rready = 1'b0;
        end else begin
            if (sw_active) begin
                k = cyc - sw_t;
                if (k == D + S + 2) begin
                    cur_mode  = pend_mode;
                    sw_active = 1'b0;
                    e_done    = 1'b1;
                end
            end
            if (sw_active) begin
                drain    = (k <= D);
                e_srst   = (k == D + 1);
                e_tready = (k >= D + 2);
                e_rready = 1'b0;
                e_busy   = 1'b1;
            end else begin
                run      = 1'b1;
                e_busy   = 1'b0; e_srst = 1'b0; e_tready = 1'b1; e_rready = 1'b1;
            end
        end
        e_mode = (sw_active && k >= D + 2) ? pend_mode : cur_mode;
        e_fs   = (e_tready && v) ? d : '0;
        nxt_v  = (run && v) || drain;
        nxt_d  = nxt_v ? bus.filt_m_tdata : '0;
        if (run && rv && (rm != cur_mode)) begin
            sw_active = 1'b1;
            sw_t      = cyc;
            pend_mode = rm;
        end

        @(negedge clk);
        capture();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        bus.s_tvalid = 1'b0; bus.s_tdata = '0; bus.mode_req_valid = 1'b0;
        bus.mode_req = 1'b0; bus.filt_m_tdata = '0;
        repeat (2) @(posedge clk);
        #1;
        pulse_reset();
        n_checks++; if ({o_mv, o_tready, o_rready, o_done, o_srst, o_mode, o_busy} !== {4'b0000, 1'b1, IM, 1'b1})
            $display("FAIL reset_flags got=%b exp=%b", {o_mv, o_tready, o_rready, o_done, o_srst, o_mode, o_busy}, {4'b0000, 1'b1, IM, 1'b1});
            else n_pass++;
        n_checks++; if (o_md !== '0) $display("FAIL reset_m_tdata got=%0h exp=0", o_md); else n_pass++;
        tick(1'b1, DW'(7), 1'b0, 1'b0);
        n_checks++; if (o_srst !== 1'b1) $display("FAIL init_srst got=%0b exp=1", o_srst); else n_pass++;
        n_checks++; if ({o_busy, o_tready, o_fs} !== {1'b1, 1'b0, DW'(0)})
            $display("FAIL init_gate got=%b/%b/%0h exp=1/0/0", o_busy, o_tready, o_fs); else n_pass++;
        tick(1'b1, DW'(9), 1'b0, 1'b0);
        n_checks++; if ({o_busy, o_tready, o_srst, o_mode} !== {e_busy, e_tready, e_srst, e_mode})
            $display("FAIL run_entry got=%b exp=%b", {o_busy, o_tready, o_srst, o_mode}, {e_busy, e_tready, e_srst, e_mode});
            else n_pass++;
    endtask

    task automatic test_stream_same_mode();
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, DW'(i + 1), (i % 3) == 0, cur_mode);
            n_checks++; if (o_mv !== e_mv) $display("FAIL stream_valid cyc=%0d got=%0b exp=%0b", o_cyc, o_mv, e_mv); else n_pass++;
            n_checks++; if (o_md !== e_md) $display("FAIL stream_data cyc=%0d got=%0h exp=%0h", o_cyc, o_md, e_md); else n_pass++;
            n_checks++; if (o_fs !== e_fs) $display("FAIL stream_filt_in cyc=%0d got=%0h exp=%0h", o_cyc, o_fs, e_fs); else n_pass++;
            n_checks++; if ({o_busy, o_rready} !== {e_busy, e_rready})
                $display("FAIL stream_busy cyc=%0d got=%b exp=%b", o_cyc, {o_busy, o_rready}, {e_busy, e_rready}); else n_pass++;
        end
    endtask

    task automatic test_bubbles();
        bit v;
        for (int i = 0; i < 16; i++) begin
            v = (i < 3) ? (i != 1) : 1'($urandom);
            tick(v, DW'($urandom), 1'b0, 1'b0);
            n_checks++; if (o_fs !== e_fs) $display("FAIL bubble_filt_in cyc=%0d got=%0h exp=%0h", o_cyc, o_fs, e_fs); else n_pass++;
            n_checks++; if ({o_mv, o_md} !== {e_mv, e_md})
                $display("FAIL bubble_out cyc=%0d got=%0b/%0h exp=%0b/%0h", o_cyc, o_mv, o_md, e_mv, e_md); else n_pass++;
        end
    endtask

    task automatic test_switch();
        tick(1'b1, DW'($urandom), 1'b1, ~cur_mode);
        for (int j = 1; j <= D + S + 3; j++) begin
            tick(1'($urandom), DW'($urandom), 1'b0, 1'b0);
            n_checks++; if ({o_mv, o_md} !== {e_mv, e_md})
                $display("FAIL switch_out k=%0d got=%0b/%0h exp=%0b/%0h", j, o_mv, o_md, e_mv, e_md); else n_pass++;
            n_checks++; if (o_fs !== e_fs) $display("FAIL switch_filt_in k=%0d got=%0h exp=%0h", j, o_fs, e_fs); else n_pass++;
            n_checks++; if (o_srst !== e_srst) $display("FAIL switch_srst k=%0d got=%0b exp=%0b", j, o_srst, e_srst); else n_pass++;
            n_checks++; if ({o_mode, o_ctrl} !== {e_mode, e_mode})
                $display("FAIL switch_mode k=%0d got=%b exp=%b", j, {o_mode, o_ctrl}, {e_mode, e_mode}); else n_pass++;
            n_checks++; if (o_done !== e_done) $display("FAIL switch_done k=%0d got=%0b exp=%0b", j, o_done, e_done); else n_pass++;
            n_checks++; if ({o_busy, o_tready, o_rready} !== {e_busy, e_tready, e_rready})
                $display("FAIL switch_status k=%0d got=%b exp=%b", j, {o_busy, o_tready, o_rready}, {e_busy, e_tready, e_rready}); else n_pass++;
        end
    endtask

    task automatic test_held_request();
        bit orig;
        orig = cur_mode;
        tick(1'b1, DW'($urandom), 1'b1, ~orig);
        for (int j = 1; j <= D + S + 3; j++) begin
            tick(1'b1, DW'($urandom), 1'b1, orig);
            n_checks++; if (o_rready !== e_rready) $display("FAIL held_ready k=%0d got=%0b exp=%0b", j, o_rready, e_rready); else n_pass++;
            n_checks++; if ({o_busy, o_done, o_mode} !== {e_busy, e_done, e_mode})
                $display("FAIL held_status k=%0d got=%b exp=%b", j, {o_busy, o_done, o_mode}, {e_busy, e_done, e_mode}); else n_pass++;
        end
        for (int j = 0; j < D + S + 3; j++) begin
            tick(1'b1, DW'($urandom), 1'b0, 1'b0);
            n_checks++; if ({o_mode, o_mv, o_md} !== {e_mode, e_mv, e_md})
                $display("FAIL back_to_back j=%0d got=%0b/%0b/%0h exp=%0b/%0b/%0h", j, o_mode, o_mv, o_md, e_mode, e_mv, e_md);
                else n_pass++;
        end
    endtask

    task automatic test_reset_mid_settle();
        pulse_reset();
        tick(1'b0, '0, 1'b0, 1'b0);
        tick(1'b1, DW'($urandom), 1'b0, 1'b0);
        tick(1'b1, DW'($urandom), 1'b1, ~IM);
        for (int j = 1; j <= 8; j++) tick(1'b1, DW'($urandom), 1'b0, 1'b0);
        n_checks++; if ({o_mode, o_busy} !== {e_mode, e_busy})
            $display("FAIL pre_abort_mode got=%b exp=%b", {o_mode, o_busy}, {e_mode, e_busy}); else n_pass++;
        pulse_reset();
        n_checks++; if ({o_mode, o_ctrl, o_srst, o_busy} !== {IM, IM, 1'b1, 1'b1})
            $display("FAIL abort_mode got=%b exp=%b", {o_mode, o_ctrl, o_srst, o_busy}, {IM, IM, 2'b11}); else n_pass++;
        n_checks++; if ({o_mv, o_md, o_tready, o_rready, o_done} !== {1'b0, DW'(0), 3'b000})
            $display("FAIL abort_outputs got=%0b/%0h/%0b/%0b/%0b exp=0/0/0/0/0", o_mv, o_md, o_tready, o_rready, o_done); else n_pass++;
        tick(1'b1, DW'($urandom), 1'b0, 1'b0);
        n_checks++; if ({o_srst, o_busy, o_mode} !== {e_srst, e_busy, e_mode})
            $display("FAIL abort_init got=%b exp=%b", {o_srst, o_busy, o_mode}, {e_srst, e_busy, e_mode}); else n_pass++;
        for (int j = 0; j < 4; j++) begin
            tick(1'b1, DW'($urandom), 1'b0, 1'b0);
            n_checks++; if ({o_busy, o_tready, o_mode, o_mv, o_md} !== {e_busy, e_tready, e_mode, e_mv, e_md})
                $display("FAIL abort_run j=%0d got=%0b/%0b/%0b/%0b/%0h exp=%0b/%0b/%0b/%0b/%0h", j,
                         o_busy, o_tready, o_mode, o_mv, o_md, e_busy, e_tready, e_mode, e_mv, e_md);
                else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream_same_mode();
        test_bubbles();
        test_switch();
        test_held_request();
        test_reset_mid_settle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
